// File: rtl/circle_gen_pkg.sv
`default_nettype none
// ============================================================
// Module   : circle_gen_pkg
// Brief    : Shared types for the circle rasteriser.
// Revision : 1.0
// ============================================================
package circle_gen_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_PLOT   = 3'd2,
    S_SPAN   = 3'd3,
    S_UPDATE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  typedef logic [2:0] octant_t;
  typedef logic [1:0] run_t;

endpackage
`default_nettype wire

// File: rtl/circ_span_walker.sv
`default_nettype none
// ============================================================
// Module   : circ_span_walker
// Brief    : Walks one horizontal run left to right, one pixel per cycle.
// Revision : 1.0
// ============================================================
module circ_span_walker
  import circle_gen_pkg::*;
#(
  parameter int W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [W-1:0] left,
  input  logic signed [W-1:0] right,
  input  logic signed [W-1:0] row,
  output logic signed [W-1:0] x,
  output logic signed [W-1:0] y,
  output logic                last
);

  logic [W-1:0] r_cnt;

  // Offset from the left end; rewinds after the last pixel so the next run starts at its own left.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt <= '0;
    end else if (last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign x    = left + r_cnt;
  assign y    = row;
  assign last = (x == right);

endmodule
`default_nettype wire

// File: rtl/circle_gen.sv
`default_nettype none
// ============================================================
// Module   : circle_gen
// Brief    : Midpoint circle rasteriser, outline or filled disc.
// Revision : 1.0
// ============================================================
module circle_gen
  import circle_gen_pkg::*;
#(
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int CW    = 3,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] centre_x,
  input  logic [YW-1:0] centre_y,
  input  logic [XW-1:0] radius,
  input  logic [CW-1:0] colour,
  input  logic [7:0]    octant_mask,
  input  logic          fill,
  output logic          done,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_plot
);

  // Wide enough that no reachable coordinate wraps into the visible window.
  localparam int SW = ((XW > YW) ? XW : YW) + 2;
  localparam logic signed [SW-1:0] c_zero    = SW'(0);
  localparam logic signed [SW-1:0] c_one     = SW'(1);
  localparam logic signed [SW-1:0] c_scr_w   = SW'(SCR_W);
  localparam logic signed [SW-1:0] c_scr_h   = SW'(SCR_H);

  state_t               r_state, w_state_nx;
  logic [XW-1:0]        r_cx, r_radius;
  logic [YW-1:0]        r_cy;
  logic [CW-1:0]        r_colour;
  logic [7:0]           r_mask;
  logic                 r_fill;
  logic signed [SW-1:0] r_ox, r_oy, r_crit;
  octant_t              r_oct;
  run_t                 r_run;

  logic signed [SW-1:0] w_cx, w_cy, w_r;
  logic signed [SW-1:0] w_ox_nx, w_oy_nx, w_crit_nx;
  logic                 w_loop;
  logic signed [SW-1:0] w_span_left, w_span_right, w_span_row, w_span_x, w_span_y;
  logic                 w_span_last;
  logic signed [SW-1:0] w_px, w_py;
  logic                 w_vis;

  assign w_cx = SW'(r_cx);
  assign w_cy = SW'(r_cy);
  assign w_r  = SW'(r_radius);

  always_comb begin
    w_oy_nx   = r_oy + c_one;
    w_ox_nx   = r_ox;
    w_crit_nx = r_crit + (w_oy_nx <<< 1) + c_one;
    if (r_crit > c_zero) begin
      w_ox_nx   = r_ox - c_one;
      w_crit_nx = r_crit + ((w_oy_nx - w_ox_nx) <<< 1) + c_one;
    end
    w_loop = (w_oy_nx <= w_ox_nx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cx     <= '0;
      r_cy     <= '0;
      r_radius <= '0;
      r_colour <= '0;
      r_mask   <= '0;
      r_fill   <= 1'b0;
      r_ox     <= '0;
      r_oy     <= '0;
      r_crit   <= '0;
      r_oct    <= '0;
      r_run    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cx     <= centre_x;
            r_cy     <= centre_y;
            r_radius <= radius;
            r_colour <= colour;
            r_mask   <= octant_mask;
            r_fill   <= fill;
          end
        end
        S_INIT: begin
          r_ox   <= w_r;
          r_oy   <= '0;
          r_crit <= c_one - w_r;
          r_oct  <= '0;
          r_run  <= '0;
        end
        S_PLOT:   r_oct <= r_oct + 3'd1;
        S_SPAN:   if (w_span_last) r_run <= r_run + 2'd1;
        S_UPDATE: begin
          r_ox   <= w_ox_nx;
          r_oy   <= w_oy_nx;
          r_crit <= w_crit_nx;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nx = S_INIT;
      S_INIT:   w_state_nx = r_fill ? S_SPAN : S_PLOT;
      S_PLOT:   if (r_oct == 3'd7) w_state_nx = S_UPDATE;
      S_SPAN:   if ((r_run == 2'd3) && w_span_last) w_state_nx = S_UPDATE;
      S_UPDATE: w_state_nx = w_loop ? (r_fill ? S_SPAN : S_PLOT) : S_DONE;
      S_DONE:   if (!start) w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // Runs 0/1 are the wide rows at cy+-oy, runs 2/3 the narrow rows at cy+-ox.
  always_comb begin
    w_span_left  = r_run[1] ? (w_cx - r_oy) : (w_cx - r_ox);
    w_span_right = r_run[1] ? (w_cx + r_oy) : (w_cx + r_ox);
    case (r_run)
      2'd0:    w_span_row = w_cy + r_oy;
      2'd1:    w_span_row = w_cy - r_oy;
      2'd2:    w_span_row = w_cy + r_ox;
      default: w_span_row = w_cy - r_ox;
    endcase
  end

  circ_span_walker #(.W(SW)) u_walker (
    .clk   (clk),
    .rst   (rst),
    .en    (r_state == S_SPAN),
    .left  (w_span_left),
    .right (w_span_right),
    .row   (w_span_row),
    .x     (w_span_x),
    .y     (w_span_y),
    .last  (w_span_last)
  );

  always_comb begin
    w_px = '0;
    w_py = '0;
    if (r_state == S_PLOT) begin
      case (r_oct)
        3'd0:    begin w_px = w_cx + r_ox; w_py = w_cy + r_oy; end
        3'd1:    begin w_px = w_cx + r_oy; w_py = w_cy + r_ox; end
        3'd2:    begin w_px = w_cx - r_ox; w_py = w_cy + r_oy; end
        3'd3:    begin w_px = w_cx - r_oy; w_py = w_cy + r_ox; end
        3'd4:    begin w_px = w_cx - r_ox; w_py = w_cy - r_oy; end
        3'd5:    begin w_px = w_cx - r_oy; w_py = w_cy - r_ox; end
        3'd6:    begin w_px = w_cx + r_ox; w_py = w_cy - r_oy; end
        default: begin w_px = w_cx + r_oy; w_py = w_cy - r_ox; end
      endcase
    end else if (r_state == S_SPAN) begin
      w_px = w_span_x;
      w_py = w_span_y;
    end
    w_vis = (w_px >= c_zero) && (w_px < c_scr_w) && (w_py >= c_zero) && (w_py < c_scr_h);
  end

  always_comb begin
    done       = (r_state == S_DONE);
    vga_plot   = ((r_state == S_PLOT) && r_mask[r_oct] && w_vis) ||
                 ((r_state == S_SPAN) && w_vis);
    vga_x      = w_px[XW-1:0];
    vga_y      = w_py[YW-1:0];
    vga_colour = vga_plot ? r_colour : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_circle_gen.sv
`default_nettype none
// ============================================================
// Module   : tb_circle_gen
// Brief    : Directed self-checking bench for circle_gen.
// Revision : 1.0
// ============================================================
module tb_circle_gen;

  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, start, fill;
  logic [XW-1:0] centre_x, radius;
  logic [YW-1:0] centre_y;
  logic [CW-1:0] colour;
  logic [7:0]    octant_mask;
  logic          done, vga_plot;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;

  circle_gen dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .centre_x    (centre_x),
    .centre_y    (centre_y),
    .radius      (radius),
    .colour      (colour),
    .octant_mask (octant_mask),
    .fill        (fill),
    .done        (done),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int qx[$], qy[$], qc[$], ex[$], ey[$];
  int n_cycles, model_iters, n_ff, n_plots;
  bit got_done;
  bit seen [0:15][0:15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold start and record every pixel strobe until done (bounded).
  task automatic draw(input int cx, input int cy, input int r, input int col,
                      input int mask, input bit f, input int budget);
    qx.delete(); qy.delete(); qc.delete();
    centre_x = XW'(cx); centre_y = YW'(cy); radius = XW'(r);
    colour = CW'(col); octant_mask = 8'(mask); fill = f;
    start = 1'b1;
    n_cycles = 0;
    got_done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        got_done = 1'b1;
        break;
      end
      n_cycles++;
      if (vga_plot) begin
        qx.push_back(int'(vga_x));
        qy.push_back(int'(vga_y));
        qc.push_back(int'(vga_colour));
      end
    end
  endtask

  // Reference midpoint outline: expected plot order with clipping and masking.
  task automatic model_outline(input int cx, input int cy, input int r, input int mask);
    int ox, oy, crit, x, y;
    ex.delete(); ey.delete();
    ox = r; oy = 0; crit = 1 - r; model_iters = 0;
    forever begin
      model_iters++;
      for (int k = 0; k < 8; k++) begin
        case (k)
          0: begin x = cx + ox; y = cy + oy; end
          1: begin x = cx + oy; y = cy + ox; end
          2: begin x = cx - ox; y = cy + oy; end
          3: begin x = cx - oy; y = cy + ox; end
          4: begin x = cx - ox; y = cy - oy; end
          5: begin x = cx - oy; y = cy - ox; end
          6: begin x = cx + ox; y = cy - oy; end
          default: begin x = cx + oy; y = cy - ox; end
        endcase
        if (((mask >> k) & 1) == 1 && x >= 0 && x < 160 && y >= 0 && y < 120) begin
          ex.push_back(x);
          ey.push_back(y);
        end
      end
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
      if (oy > ox) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int dx, dy, d2, distinct, stray;
    rst = 1'b1; start = 1'b0; fill = 1'b0;
    centre_x = '0; centre_y = '0; radius = '0; colour = '0; octant_mask = '0;
    repeat (3) tick();
    check("rst_done", done, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    rst = 1'b0;
    tick();
    check("idle_plot", vga_plot, 0);

    // Radius 0: eight plots of the centre, INIT + 8 PLOT + UPDATE = 10 cycles.
    draw(80, 60, 0, 5, 8'hFF, 1'b0, 100);
    check("r0_done", got_done, 1);
    check("r0_cycles", n_cycles, 10);
    check("r0_plots", qx.size(), 8);
    foreach (qx[i]) begin
      check("r0_x", qx[i], 80);
      check("r0_y", qy[i], 60);
      check("r0_colour", qc[i], 5);
    end
    tick();
    check("done_hold", done, 1);
    start = 1'b0;
    tick();
    check("r0_idle_done", done, 0);
    check("r0_idle_plot", vga_plot, 0);

    // Radius 40, all octants.
    draw(80, 60, 40, 3, 8'hFF, 1'b0, 1000);
    model_outline(80, 60, 40, 8'hFF);
    n_ff = n_cycles;
    check("r40_done", got_done, 1);
    check("r40_cycles", n_cycles, 1 + 9 * model_iters);
    check("r40_plots", qx.size(), ex.size());
    check("r40_p0x", qx[0], 120); check("r40_p0y", qy[0], 60);
    check("r40_p1x", qx[1], 80);  check("r40_p1y", qy[1], 100);
    check("r40_p2x", qx[2], 40);  check("r40_p2y", qy[2], 60);
    check("r40_p3x", qx[3], 80);  check("r40_p3y", qy[3], 100);
    if (qx.size() == ex.size()) begin
      foreach (qx[i]) begin
        check("r40_seq_x", qx[i], ex[i]);
        check("r40_seq_y", qy[i], ey[i]);
      end
    end
    foreach (qx[i]) begin
      dx = qx[i] - 80; dy = qy[i] - 60; d2 = dx * dx + dy * dy;
      check("r40_band", (d2 >= 1521 && d2 <= 1681), 1);
      check("r40_colour", qc[i], 3);
    end
    start = 1'b0;
    tick();

    // Octant 0 only: same cycle count, one plot per iteration.
    draw(80, 60, 40, 6, 8'h01, 1'b0, 1000);
    check("m01_done", got_done, 1);
    check("m01_cycles", n_cycles, n_ff);
    check("m01_plots", qx.size(), model_iters);
    foreach (qx[i]) begin
      check("m01_octant0", (qx[i] >= 80 && qy[i] >= 60 && (qy[i] - 60) <= (qx[i] - 80)), 1);
    end
    start = 1'b0;
    tick();

    // Near the top-left corner: negative coordinates must be suppressed.
    draw(2, 2, 5, 7, 8'hFF, 1'b0, 500);
    model_outline(2, 2, 5, 8'hFF);
    check("clip_done", got_done, 1);
    check("clip_plots", qx.size(), ex.size());
    check("clip_suppressed", (qx.size() < 8 * model_iters), 1);
    foreach (qx[i]) check("clip_bounds", (qx[i] < 160 && qy[i] < 120), 1);
    if (qx.size() == ex.size()) begin
      foreach (qx[i]) begin
        check("clip_seq_x", qx[i], ex[i]);
        check("clip_seq_y", qy[i], ey[i]);
      end
    end
    start = 1'b0;
    tick();

    // Filled disc r=2: 12 + 16 span pixels, INIT + 12 + UPDATE + 16 + UPDATE = 31 cycles.
    draw(10, 10, 2, 2, 8'h00, 1'b1, 200);
    check("fill_done", got_done, 1);
    check("fill_cycles", n_cycles, 31);
    check("fill_plots", qx.size(), 28);
    check("fill_first_x", qx[0], 8);
    check("fill_first_y", qy[0], 10);
    check("fill_last_x", qx[qx.size() - 1], 11);
    check("fill_last_y", qy[qy.size() - 1], 8);
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) seen[y][x] = 1'b0;
    stray = 0;
    foreach (qx[i]) begin
      if (qx[i] < 16 && qy[i] < 16) seen[qy[i]][qx[i]] = 1'b1;
      else stray++;
    end
    distinct = 0;
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) if (seen[y][x]) distinct++;
    check("fill_stray", stray, 0);
    check("fill_distinct", distinct, 21);
    for (int y = 8; y <= 12; y++) begin
      for (int x = 8; x <= 12; x++) begin
        check("fill_cover", seen[y][x], ((y >= 9 && y <= 11) || (x >= 9 && x <= 11)) ? 1 : 0);
      end
    end
    start = 1'b0;
    tick();

    // Reset in the middle of a draw.
    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd40; colour = 3'd4;
    octant_mask = 8'hFF; fill = 1'b0; start = 1'b1;
    repeat (20) tick();
    rst = 1'b1; start = 1'b0;
    tick();
    check("midrst_plot", vga_plot, 0);
    check("midrst_done", done, 0);
    check("midrst_x", vga_x, 0);
    check("midrst_y", vga_y, 0);
    check("midrst_colour", vga_colour, 0);
    rst = 1'b0;
    n_plots = 0;
    repeat (30) begin
      tick();
      if (vga_plot || done) n_plots++;
    end
    check("midrst_quiet", n_plots, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/circle_gen.md
CIRCLE_GEN -- requirements
Module: circle_gen

Interface
REQ-001 Parameter XW, default 8, x-coordinate and radius width.
REQ-002 Parameter YW, default 7, y-coordinate width.
REQ-003 Parameter CW, default 3, colour width.
REQ-004 Parameter SCR_W, default 160, visible columns.
REQ-005 Parameter SCR_H, default 120, visible rows.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  request; held high by the requester until done is seen.
REQ-009 centre_x  in  XW  circle centre column.
REQ-010 centre_y  in  YW  circle centre row.
REQ-011 radius  in  XW  radius in pixels.
REQ-012 colour  in  CW  drawing colour.
REQ-013 octant_mask  in  8  bit k enables octant k in outline mode.
REQ-014 fill  in  1  1 = filled disc, 0 = outline.
REQ-015 done  out  1  drawing complete.
REQ-016 vga_x  out  XW, vga_y  out  YW, vga_colour  out  CW, vga_plot  out  1  pixel write strobe, one pixel per cycle.

Function
REQ-017 States: IDLE, INIT, PLOT, SPAN, UPDATE, DONE.
REQ-018 IDLE with start=1 at an edge: latch all inputs, go to INIT; inputs are ignored at all other times.
REQ-019 INIT: offset_x=radius, offset_y=0, crit=1-radius (signed, XW+2 bits), octant=0; go to PLOT (outline) or SPAN (fill).
REQ-020 Octant map: 0 (cx+ox,cy+oy), 1 (cx+oy,cy+ox), 2 (cx-ox,cy+oy), 3 (cx-oy,cy+ox), 4 (cx-ox,cy-oy), 5 (cx-oy,cy-ox), 6 (cx+ox,cy-oy), 7 (cx+oy,cy-ox).
REQ-021 PLOT: one octant per cycle, 0..7 in order, always 8 cycles; vga_plot=1 only if octant_mask bit set and pixel visible.
REQ-022 Visible means 0<=x<SCR_W and 0<=y<SCR_H, computed signed at XW+2/YW+2 bits; no wrap-around ever produces a plot.
REQ-023 SPAN: four horizontal runs per iteration in order: row cy+oy and cy-oy over cx-ox..cx+ox, rows cy+ox and cy-ox over cx-oy..cx+oy; one pixel per cycle, left to right; octant_mask ignored; invisible pixels consume a cycle with vga_plot=0.
REQ-024 UPDATE (1 cycle, vga_plot=0): oy+=1; if crit<=0 then crit+=2*oy+1 else ox-=1, crit+=2*(oy-ox)+1 (new values); if oy<=ox return to PLOT/SPAN else DONE.
REQ-025 DONE: done=1, vga_plot=0; stay while start=1; start=0 -> IDLE.
REQ-026 vga_colour equals latched colour whenever vga_plot=1; vga_x/vga_y carry the low bits of the current coordinate.
REQ-027 radius=0: one iteration; outline plots (cx,cy) for each enabled octant; fill plots (cx,cy) four times.
REQ-028 Duplicate pixels (overlapping octants/runs) are plotted again, not suppressed.

Reset
REQ-029 rst=1 at any edge, including mid-draw: state=IDLE, done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, all counters cleared; no further plot until a new start.

Structure
REQ-030 Package circle_gen_pkg holds the state enum and octant index type.
REQ-031 One sub-module circ_span_walker: given left x, right x, row, it steps one pixel per cycle and flags the last pixel of a run.

Verification
REQ-032 rst held 3 cycles -> all outputs 0, state IDLE; rst asserted mid-draw -> vga_plot=0 next cycle, IDLE.
REQ-033 Outline (80,60) r=0 mask 0xFF -> eight plots at (80,60), then done=1; start=0 -> IDLE, done=0.
REQ-034 Outline (80,60) r=40 mask 0xFF -> first plots (120,60),(80,100),(40,60),(80,100); done follows last pixel; every plotted point lies within 1 pixel of radius 40.
REQ-035 Same with mask 0x01 -> only octant 0 points plotted (x>=80,y>=60, dy<=dx); cycle count identical to mask 0xFF.
REQ-036 Outline (2,2) r=5 -> no plot with x or y outside 0..159/0..119; pixels at negative coordinates suppressed.
REQ-037 Fill (10,10) r=2 -> 28 vga_plot pulses covering exactly 21 distinct pixels (rows 9-11 x 8-12, rows 8,12 x 9-11).
